// File: rtl/riscv_dcache_pkg.sv
// Shared types and helpers for the direct-mapped,
// write-through data cache.
package riscv_dcache_pkg;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;
  localparam int WORD_W = $clog2(DEF_WORDS);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = 32 - IDX_W - WORD_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    REFILL_REQ,
    REFILL_WAIT,
    WRITE,
    DONE
  } state_t;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] din,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (mask[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/riscv_dcache_if.sv
// CPU data port and backing-memory word port of
// the data cache; slave is the cache side.
interface riscv_dcache_if;

  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  dcache_addr, dcache_we, dcache_re,
    input  dcache_din,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_data,
    output dcache_dout, stall,
    output mem_req_valid, mem_req_rw,
    output mem_req_addr, mem_req_data,
    output mem_req_mask
  );

  modport master (
    output dcache_addr, dcache_we, dcache_re,
    output dcache_din,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_data,
    input  dcache_dout, stall,
    input  mem_req_valid, mem_req_rw,
    input  mem_req_addr, mem_req_data,
    input  mem_req_mask
  );

endinterface

// File: rtl/riscv_dcache_line_store.sv
// Tag, valid and data arrays held in flops with
// combinational lookup; clr wipes every valid bit.
module dcache_line_store
  import riscv_dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_LINES,
  parameter int LINE_WORDS = DEF_WORDS,
  localparam int IW = $clog2(NUM_LINES),
  localparam int WW = $clog2(LINE_WORDS),
  localparam int TW = 32 - IW - WW - 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [IW-1:0] rd_index,
  input  logic [WW-1:0] rd_word,
  input  logic [TW-1:0] rd_tag,
  output logic          hit,
  output logic [31:0]   rd_data,
  input  logic          word_we,
  input  logic          merge_we,
  input  logic [IW-1:0] wr_index,
  input  logic [WW-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_mask,
  input  logic          fill,
  input  logic [TW-1:0] fill_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0] tags [NUM_LINES];
  logic [31:0] data [NUM_LINES*LINE_WORDS];

  logic [IW+WW-1:0] ra;
  logic [IW+WW-1:0] wa;

  assign ra = {rd_index, rd_word};
  assign wa = {wr_index, wr_word};
  assign hit = valid[rd_index] &&
               (tags[rd_index] == rd_tag);
  assign rd_data = data[ra];

  always_ff @(posedge clk) begin
    if (word_we)
      data[wa] <= wr_data;
    else if (merge_we)
      data[wa] <= byte_merge(data[wa], wr_data,
                             wr_mask);
    if (fill)
      tags[wr_index] <= fill_tag;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      valid <= '0;
    else if (fill)
      valid[wr_index] <= 1'b1;
  end

endmodule

// File: rtl/riscv_dcache.sv
// Direct-mapped write-through no-write-allocate
// data cache with blocking word-by-word refill.
module riscv_dcache
  import riscv_dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_LINES,
  parameter int LINE_WORDS = DEF_WORDS,
  localparam int IW = $clog2(NUM_LINES),
  localparam int WW = $clog2(LINE_WORDS),
  localparam int TW = 32 - IW - WW - 2
) (
  input logic            clk,
  input logic            reset,
  riscv_dcache_if.slave  bus
);

  state_t state;
  logic [WW-1:0] cnt;
  logic [WW-1:0] cnt_nxt;
  logic [TW+IW-1:0] base;
  logic [31:0] dout;
  logic req_valid, req_rw;
  logic [31:0] req_addr, req_data;
  logic [3:0] req_mask;

  logic [TW+IW-1:0] a_line;
  logic [IW-1:0] a_idx;
  logic [WW-1:0] a_word;
  logic [TW-1:0] a_tag;
  logic st_req, ld_req, hit, last;
  logic [31:0] rd_data;
  logic resp_en, merge_en, in_write;
  logic unused_ok;

  assign a_line = bus.dcache_addr[31:WW+2];
  assign a_word = bus.dcache_addr[WW+1:2];
  assign a_idx = a_line[IW-1:0];
  assign a_tag = a_line[TW+IW-1:IW];
  assign unused_ok = ^bus.dcache_addr[1:0];

  assign st_req = |bus.dcache_we;
  assign ld_req = !st_req && bus.dcache_re;
  assign cnt_nxt = cnt + WW'(1);
  assign last = (cnt == WW'(LINE_WORDS-1));
  assign in_write = (state == WRITE);
  assign resp_en = (state == REFILL_WAIT) &&
                   bus.mem_resp_valid;
  assign merge_en = in_write && bus.mem_req_ready &&
                    hit;

  dcache_line_store #(
    .NUM_LINES(NUM_LINES),
    .LINE_WORDS(LINE_WORDS)
  ) u_store (
    .clk(clk),
    .clr(reset),
    .rd_index(a_idx),
    .rd_word(a_word),
    .rd_tag(a_tag),
    .hit(hit),
    .rd_data(rd_data),
    .word_we(resp_en),
    .merge_we(merge_en),
    .wr_index(in_write ? a_idx : base[IW-1:0]),
    .wr_word(in_write ? a_word : cnt),
    .wr_data(in_write ? bus.dcache_din
                      : bus.mem_resp_data),
    .wr_mask(bus.dcache_we),
    .fill(resp_en && last),
    .fill_tag(base[TW+IW-1:IW])
  );

  always_comb begin
    bus.stall = 1'b1;
    unique case (state)
      IDLE: bus.stall = st_req || (ld_req && !hit);
      DONE: bus.stall = 1'b0;
      default: bus.stall = 1'b1;
    endcase
  end

  assign bus.dcache_dout = dout;
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_rw = req_rw;
  assign bus.mem_req_addr = req_addr;
  assign bus.mem_req_data = req_data;
  assign bus.mem_req_mask = req_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      dout <= '0;
      req_valid <= 1'b0;
      req_rw <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      req_mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (st_req) begin
            state <= WRITE;
            req_valid <= 1'b1;
            req_rw <= 1'b1;
            req_addr <= {bus.dcache_addr[31:2], 2'b00};
            req_data <= bus.dcache_din;
            req_mask <= bus.dcache_we;
          end else if (ld_req && hit) begin
            dout <= rd_data;
          end else if (ld_req) begin
            state <= REFILL_REQ;
            base <= a_line;
            cnt <= '0;
            req_valid <= 1'b1;
            req_rw <= 1'b0;
            req_addr <= {a_line, {(WW+2){1'b0}}};
            req_data <= '0;
            req_mask <= '0;
          end
        end
        REFILL_REQ: begin
          if (bus.mem_req_ready) begin
            req_valid <= 1'b0;
            state <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (bus.mem_resp_valid && last) begin
            state <= IDLE;
          end else if (bus.mem_resp_valid) begin
            cnt <= cnt_nxt;
            state <= REFILL_REQ;
            req_valid <= 1'b1;
            req_addr <= {base, cnt_nxt, 2'b00};
          end
        end
        WRITE: begin
          if (bus.mem_req_ready) begin
            req_valid <= 1'b0;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dcache.sv
// Directed bench for riscv_dcache with a word
// memory model and expected-value queues.
module tb_riscv_dcache;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_dcache_if bus ();

  riscv_dcache dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int ncmp = 0;
  int nfail = 0;

  req_t act_q[$];
  req_t exp_q[$];
  logic [31:0] exp_dout_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rsp_data_q[$];
  int rsp_wait_q[$];
  int hold = 0;
  req_t mon_r;
  logic [31:0] last_dout = 32'h0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // memory side: log accepted requests, answer reads 2 cycles later
  always @(posedge clk) begin
    if (!reset && bus.mem_req_valid && bus.mem_req_ready) begin
      mon_r.rw = bus.mem_req_rw;
      mon_r.addr = bus.mem_req_addr;
      mon_r.data = bus.mem_req_rw ? bus.mem_req_data : 32'h0;
      mon_r.mask = bus.mem_req_rw ? bus.mem_req_mask : 4'h0;
      act_q.push_back(mon_r);
      if (bus.mem_req_rw) begin
        logic [31:0] w;
        w = rd(bus.mem_req_addr);
        for (int b = 0; b < 4; b++)
          if (bus.mem_req_mask[b])
            w[8*b +: 8] = bus.mem_req_data[8*b +: 8];
        mem[bus.mem_req_addr] = w;
      end else begin
        rsp_data_q.push_back(rd(bus.mem_req_addr));
        rsp_wait_q.push_back(2);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_req_valid && hold > 0) hold--;
    bus.mem_req_ready = (hold == 0);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 32'h0;
    if (rsp_wait_q.size() > 0) begin
      if (rsp_wait_q[0] <= 1) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = rsp_data_q.pop_front();
        void'(rsp_wait_q.pop_front());
      end else begin
        rsp_wait_q[0] = rsp_wait_q[0] - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_refill(input logic [31:0] b);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({1'b0, b + 32'(4 * i), 32'h0, 4'h0});
  endtask

  task automatic check_reqs(input string tag);
    req_t a, e;
    chk({tag, " nreq"}, 72'(act_q.size()), 72'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, " req"}, 72'(a), 72'(e));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] e,
                         input int exp_stall, input string tag);
    int n = 0;
    exp_dout_q.push_back(e);
    bus.dcache_addr = a;
    bus.dcache_we = 4'h0;
    bus.dcache_re = 1'b1;
    #1;
    while (bus.stall && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, " stall"}, 72'(n), 72'(exp_stall));
    @(posedge clk); #1;
    bus.dcache_re = 1'b0;
    last_dout = exp_dout_q.pop_front();
    chk({tag, " dout"}, 72'(bus.dcache_dout), 72'(last_dout));
    check_reqs(tag);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] d, input int exp_stall,
                          input string tag);
    int n = 0;
    req_t e;
    e = {1'b1, a[31:2], 2'b00, d, we};
    exp_q.push_back(e);
    bus.dcache_addr = a;
    bus.dcache_din = d;
    bus.dcache_we = we;
    bus.dcache_re = 1'b1;
    #1;
    while (bus.stall && n < 200) begin
      if (bus.mem_req_valid)
        chk({tag, " held"},
            72'({bus.mem_req_rw, bus.mem_req_addr,
                 bus.mem_req_data, bus.mem_req_mask}), 72'(e));
      n++;
      @(posedge clk); #1;
    end
    chk({tag, " stall"}, 72'(n), 72'(exp_stall));
    @(posedge clk); #1;
    bus.dcache_we = 4'h0;
    bus.dcache_re = 1'b0;
    chk({tag, " dout hold"}, 72'(bus.dcache_dout), 72'(last_dout));
    check_reqs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      mem[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
      mem[32'h1100 + 32'(4 * i)] = 32'hB0 + 32'(i);
      mem[32'h3000 + 32'(4 * i)] = 32'hC0 + 32'(i);
    end
    reset = 1'b1;
    bus.dcache_addr = 32'h0;
    bus.dcache_we = 4'h0;
    bus.dcache_re = 1'b0;
    bus.dcache_din = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset dout", 72'(bus.dcache_dout), 72'h0);
    chk("reset valid", 72'(bus.mem_req_valid), 72'h0);
    chk("reset stall", 72'(bus.stall), 72'h0);
    @(posedge clk); #1;

    exp_refill(32'h1000);
    do_load(32'h1008, 32'hA2, 13, "cold load");
    do_load(32'h100C, 32'hA3, 0, "hit load");

    hold = 3;
    do_store(32'h1004, 4'b0010, 32'h0000_5500, 4, "store hit");
    do_load(32'h1004, 32'h0000_55A1, 0, "merged load");

    do_store(32'h2000, 4'hF, 32'hDEAD_BEEF, 2, "store miss");
    exp_refill(32'h2000);
    do_load(32'h2000, 32'hDEAD_BEEF, 13, "after store miss");

    exp_refill(32'h1000);
    do_load(32'h1000, 32'hA0, 13, "conflict a");
    exp_refill(32'h1100);
    do_load(32'h1104, 32'hB1, 13, "conflict b");
    exp_refill(32'h1000);
    do_load(32'h1000, 32'hA0, 13, "conflict reload");
    do_load(32'h1004, 32'h0000_55A1, 0, "write-through");

    // abort a refill while the first response is in flight
    bus.dcache_addr = 32'h3000;
    bus.dcache_re = 1'b1;
    n = 0;
    while (act_q.size() == 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("abort accepted", 72'(act_q.size()), 72'd1);
    reset = 1'b1;
    bus.dcache_re = 1'b0;
    #1;
    chk("abort valid", 72'(bus.mem_req_valid), 72'h0);
    chk("abort stall", 72'(bus.stall), 72'h0);
    chk("abort dout", 72'(bus.dcache_dout), 72'h0);
    #2 reset = 1'b0;
    act_q.delete();
    last_dout = 32'h0;
    mem[32'h3000] = 32'hC5;
    repeat (3) @(posedge clk);
    #1;
    chk("stale drained", 72'(rsp_wait_q.size()), 72'd0);
    exp_refill(32'h3000);
    do_load(32'h3000, 32'hC5, 13, "post abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
